// File: rtl/ehl_pkg.sv
// ehl_pkg: constants and helpers shared by the ehl_ primitives.
// Holds the TECHNOLOGY encoding and the pipeline depth ceiling.
package ehl_pkg;

  localparam int EHL_DFF_PIPE_MAX_DEPTH = 16;

  localparam int TECH_GENERIC = 0;
  localparam int TECH_MAPPED  = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/ehl_dff_pipe_if.sv
// ehl_dff_pipe_if: valid/ready bus on both sides of the pipe.
// The slave modport is the pipeline's view, master the user's.
interface ehl_dff_pipe_if
  import ehl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
);

  localparam int OW = clog2(DEPTH + 1);

  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [OW-1:0]    occupancy;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, occupancy
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, occupancy
  );

endinterface

// File: rtl/ehl_dff_pipe_stage.sv
// ehl_dff_pipe_stage: one valid bit plus a data register.
// TECHNOLOGY selects enable flops or mux-in-front mapped cells.
module ehl_dff_pipe_stage
  import ehl_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               TECHNOLOGY  = TECH_GENERIC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_adv,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_dat,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_dat
);

  logic             r_vld;
  logic [WIDTH-1:0] r_dat;

  if (TECHNOLOGY == TECH_GENERIC) begin : g_generic
    // Enable-style flops: data loads only when a valid word moves in
    always_ff @(posedge clk) begin
      if (reset) begin
        r_vld <= 1'b0;
        r_dat <= RESET_VALUE;
      end else if (i_clr) begin
        r_vld <= 1'b0;
      end else if (i_adv) begin
        r_vld <= i_vld;
        if (i_vld) r_dat <= i_dat;
      end
    end
  end else begin : g_mapped
    logic             w_vld_d;
    logic [WIDTH-1:0] w_dat_d;
    logic             w_dat_en;

    assign w_dat_en = i_adv & i_vld & ~i_clr;
    assign w_vld_d  = (reset | i_clr) ? 1'b0
                    : i_adv ? i_vld : r_vld;
    assign w_dat_d  = reset ? RESET_VALUE
                    : w_dat_en ? i_dat : r_dat;

    // Plain library flops fed by an explicit hold mux
    always_ff @(posedge clk) begin
      r_vld <= w_vld_d;
      r_dat <= w_dat_d;
    end
  end

  assign o_vld = r_vld;
  assign o_dat = r_dat;

endmodule

// File: rtl/ehl_dff_pipe.sv
// ehl_dff_pipe: elastic WIDTH x DEPTH register pipeline.
// Optional flush input when EHL_DFF_PIPE_FLUSH_EN is defined.
module ehl_dff_pipe
  import ehl_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               TECHNOLOGY  = TECH_GENERIC
) (
  input  logic          clk,
  input  logic          reset,
`ifdef EHL_DFF_PIPE_FLUSH_EN
  input  logic          flush,
`endif
  ehl_dff_pipe_if.slave bus
);

  localparam int OW = clog2(DEPTH + 1);

  logic [DEPTH-1:0] w_vld;
  logic [DEPTH-1:0] w_rdy;
  logic [WIDTH-1:0] w_dat [DEPTH];
  logic             w_clr;
  logic             w_s_ready;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [OW-1:0]    r_occ;

`ifdef EHL_DFF_PIPE_FLUSH_EN
  assign w_clr = flush;
`else
  assign w_clr = 1'b0;
`endif

  // Ready ripples back from the sink so bubbles get filled
  always_comb begin
    logic r;
    w_rdy = '0;
    r = ~w_vld[DEPTH-1] | bus.m_ready;
    w_rdy[DEPTH-1] = r;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      r = ~w_vld[i] | r;
      w_rdy[i] = r;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic             w_in_vld;
    logic [WIDTH-1:0] w_in_dat;

    if (g == 0) begin : g_head
      assign w_in_vld = bus.s_valid;
      assign w_in_dat = bus.s_data;
    end else begin : g_body
      assign w_in_vld = w_vld[g-1];
      assign w_in_dat = w_dat[g-1];
    end

    ehl_dff_pipe_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE),
      .TECHNOLOGY  (TECHNOLOGY)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .i_clr (w_clr),
      .i_adv (w_rdy[g]),
      .i_vld (w_in_vld),
      .i_dat (w_in_dat),
      .o_vld (w_vld[g]),
      .o_dat (w_dat[g])
    );
  end

  assign w_s_ready  = w_rdy[0] & ~reset & ~w_clr;
  assign w_in_xfer  = bus.s_valid & w_s_ready;
  assign w_out_xfer = w_vld[DEPTH-1] & bus.m_ready;

  // Occupancy tracks words held: +1 on accept, -1 on emit
  always_ff @(posedge clk) begin
    if (reset || w_clr) begin
      r_occ <= '0;
    end else if (w_in_xfer && !w_out_xfer) begin
      r_occ <= r_occ + 1'b1;
    end else if (!w_in_xfer && w_out_xfer) begin
      r_occ <= r_occ - 1'b1;
    end
  end

  assign bus.s_ready   = w_s_ready;
  assign bus.m_valid   = w_vld[DEPTH-1];
  assign bus.m_data    = w_dat[DEPTH-1];
  assign bus.occupancy = r_occ;

endmodule

// File: tb/tb_ehl_dff_pipe.sv
// tb_ehl_dff_pipe: scoreboard bench for ehl_dff_pipe.
// Flush scenario is built when EHL_DFF_PIPE_FLUSH_EN is defined.
module tb_ehl_dff_pipe;

  localparam logic [7:0] RV3 = 8'h00;
  localparam logic [7:0] RV4 = 8'hE7;

  logic clk;
  logic reset;
  logic flush;
  logic mon_en;
  int   n_tests;
  int   n_fail;

  logic [7:0] q3 [$];
  logic [7:0] q4 [$];
  logic [7:0] exp3;
  logic [7:0] exp4;
  logic       stall_prev;
  logic [7:0] hold_prev;

  ehl_dff_pipe_if #(.WIDTH(8), .DEPTH(3)) bus3 ();
  ehl_dff_pipe_if #(.WIDTH(8), .DEPTH(4)) bus4 ();
  ehl_dff_pipe_if #(.WIDTH(8), .DEPTH(4)) bus4m ();

  assign bus4m.s_valid = bus4.s_valid;
  assign bus4m.s_data  = bus4.s_data;
  assign bus4m.m_ready = bus4.m_ready;

  ehl_dff_pipe #(
    .WIDTH(8), .DEPTH(3), .RESET_VALUE(RV3), .TECHNOLOGY(0)
  ) u_d3 (
    .clk   (clk),
    .reset (reset),
`ifdef EHL_DFF_PIPE_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus3)
  );

  ehl_dff_pipe #(
    .WIDTH(8), .DEPTH(4), .RESET_VALUE(RV4), .TECHNOLOGY(0)
  ) u_d4 (
    .clk   (clk),
    .reset (reset),
`ifdef EHL_DFF_PIPE_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus4)
  );

  ehl_dff_pipe #(
    .WIDTH(8), .DEPTH(4), .RESET_VALUE(RV4), .TECHNOLOGY(1)
  ) u_d4m (
    .clk   (clk),
    .reset (reset),
`ifdef EHL_DFF_PIPE_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus4m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard for the 3-deep pipe
  always @(negedge clk) begin
    if (mon_en) begin
      n_tests++;
      if (32'(bus3.occupancy) !== 32'(q3.size())) begin
        n_fail++;
        $display("FAIL occ3 got %0d exp %0d",
                 bus3.occupancy, q3.size());
      end
      if (reset || flush) begin
        q3.delete();
      end else begin
        if (bus3.m_valid === 1'b1 && bus3.m_ready === 1'b1) begin
          n_tests++;
          if (q3.size() == 0) begin
            n_fail++;
            $display("FAIL out3 got %h exp none", bus3.m_data);
          end else begin
            exp3 = q3.pop_front();
            if (bus3.m_data !== exp3) begin
              n_fail++;
              $display("FAIL out3 got %h exp %h",
                       bus3.m_data, exp3);
            end
          end
        end
        if (bus3.s_valid === 1'b1 && bus3.s_ready === 1'b1)
          q3.push_back(bus3.s_data);
      end
    end
  end

  // Scoreboard, hold check and generic-vs-mapped lockstep for 4-deep
  always @(negedge clk) begin
    if (mon_en) begin
      n_tests++;
      if (32'(bus4.occupancy) !== 32'(q4.size())) begin
        n_fail++;
        $display("FAIL occ4 got %0d exp %0d",
                 bus4.occupancy, q4.size());
      end
      n_tests++;
      if ({bus4.s_ready, bus4.m_valid, bus4.m_data,
           bus4.occupancy} !==
          {bus4m.s_ready, bus4m.m_valid, bus4m.m_data,
           bus4m.occupancy}) begin
        n_fail++;
        $display("FAIL lockstep rtl %b/%b/%h/%0d map %b/%b/%h/%0d",
                 bus4.s_ready, bus4.m_valid, bus4.m_data,
                 bus4.occupancy, bus4m.s_ready, bus4m.m_valid,
                 bus4m.m_data, bus4m.occupancy);
      end
      if (stall_prev) begin
        n_tests++;
        if (bus4.m_valid !== 1'b1 || bus4.m_data !== hold_prev) begin
          n_fail++;
          $display("FAIL hold4 got %b/%h exp 1/%h",
                   bus4.m_valid, bus4.m_data, hold_prev);
        end
      end
      stall_prev = (bus4.m_valid === 1'b1) && !bus4.m_ready
                   && !reset && !flush;
      hold_prev = bus4.m_data;
      if (reset || flush) begin
        q4.delete();
      end else begin
        if (bus4.m_valid === 1'b1 && bus4.m_ready === 1'b1) begin
          n_tests++;
          if (q4.size() == 0) begin
            n_fail++;
            $display("FAIL out4 got %h exp none", bus4.m_data);
          end else begin
            exp4 = q4.pop_front();
            if (bus4.m_data !== exp4) begin
              n_fail++;
              $display("FAIL out4 got %h exp %h",
                       bus4.m_data, exp4);
            end
          end
        end
        if (bus4.s_valid === 1'b1 && bus4.s_ready === 1'b1)
          q4.push_back(bus4.s_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus3.s_valid = 1'b1; bus3.s_data = 8'hA5; bus3.m_ready = 1'b1;
    bus4.s_valid = 1'b1; bus4.s_data = 8'hA5; bus4.m_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      mon_en = 1'b1;
      n_tests += 2;
      if ({bus3.m_valid, bus3.m_data, bus3.occupancy, bus3.s_ready}
          !== {1'b0, RV3, 2'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset3 got v%b d%h o%0d r%b exp v0 d%h o0 r0",
                 bus3.m_valid, bus3.m_data, bus3.occupancy,
                 bus3.s_ready, RV3);
      end
      if ({bus4.m_valid, bus4.m_data, bus4.occupancy, bus4.s_ready}
          !== {1'b0, RV4, 3'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset4 got v%b d%h o%0d r%b exp v0 d%h o0 r0",
                 bus4.m_valid, bus4.m_data, bus4.occupancy,
                 bus4.s_ready, RV4);
      end
    end
    reset = 1'b0;
    bus3.s_valid = 1'b0;
    bus4.s_valid = 1'b0;
    #1;
    n_tests++;
    if (bus3.s_ready !== 1'b1 || bus4.s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL release_ready got %b%b exp 11",
               bus3.s_ready, bus4.s_ready);
    end
  endtask

  task automatic test_latency();
    bus3.m_ready = 1'b1;
    bus3.s_valid = 1'b1;
    bus3.s_data  = 8'h3C;
    step();
    bus3.s_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      n_tests++;
      if (bus3.occupancy !== 2'd1 ||
          bus3.m_valid !== (k == 3)) begin
        n_fail++;
        $display("FAIL latency c%0d got o%0d v%b exp o1 v%b",
                 k, bus3.occupancy, bus3.m_valid, k == 3);
      end
      if (k == 3) begin
        n_tests++;
        if (bus3.m_data !== 8'h3C) begin
          n_fail++;
          $display("FAIL latency_data got %h exp 3c", bus3.m_data);
        end
      end
      step();
    end
    n_tests++;
    if (bus3.m_valid !== 1'b0 || bus3.occupancy !== 2'd0) begin
      n_fail++;
      $display("FAIL latency_drain got v%b o%0d exp v0 o0",
               bus3.m_valid, bus3.occupancy);
    end
  endtask

  task automatic test_backpressure();
    int  w;
    int  n_acc;
    logic acc;
    w = 1;
    n_acc = 0;
    bus4.m_ready = 1'b0;
    bus4.s_valid = 1'b1;
    bus4.s_data  = 8'(w);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      acc = bus4.s_valid & bus4.s_ready;
      step();
      if (acc) begin
        n_acc++;
        w++;
        bus4.s_data = 8'(w);
      end
    end
    n_tests++;
    if (n_acc != 4 || bus4.s_ready !== 1'b0 ||
        bus4.occupancy !== 3'd4) begin
      n_fail++;
      $display("FAIL bp_fill got acc%0d r%b o%0d exp acc4 r0 o4",
               n_acc, bus4.s_ready, bus4.occupancy);
    end
    bus4.m_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_tests++;
      if (bus4.m_valid !== 1'b1 || bus4.m_data !== 8'(k + 1)) begin
        n_fail++;
        $display("FAIL bp_drain k%0d got v%b d%h exp v1 d%h",
                 k, bus4.m_valid, bus4.m_data, 8'(k + 1));
      end
      if (k == 0) begin
        n_tests++;
        if (bus4.s_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_passthru got r%b exp r1", bus4.s_ready);
        end
      end
      acc = bus4.s_valid & bus4.s_ready;
      step();
      if (acc) bus4.s_valid = 1'b0;
    end
    step();
    n_tests++;
    if (bus4.m_valid !== 1'b0 || bus4.occupancy !== 3'd0) begin
      n_fail++;
      $display("FAIL bp_empty got v%b o%0d exp v0 o0",
               bus4.m_valid, bus4.occupancy);
    end
  endtask

  task automatic test_bubble();
    bus4.m_ready = 1'b1;
    bus4.s_valid = 1'b1; bus4.s_data = 8'hA1;
    step();
    bus4.s_valid = 1'b0;
    step();
    bus4.s_valid = 1'b1; bus4.s_data = 8'hB2;
    step();
    bus4.s_valid = 1'b0;
    bus4.m_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_tests++;
      if (bus4.s_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL bubble_ready c%0d got %b exp 1",
                 c, bus4.s_ready);
      end
      step();
    end
    n_tests++;
    if (bus4.occupancy !== 3'd2 || bus4.m_valid !== 1'b1 ||
        bus4.m_data !== 8'hA1 || bus4.s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bubble got o%0d v%b d%h r%b exp o2 v1 da1 r1",
               bus4.occupancy, bus4.m_valid, bus4.m_data,
               bus4.s_ready);
    end
    bus4.m_ready = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_midreset();
    bus4.m_ready = 1'b0;
    bus4.s_valid = 1'b1;
    bus4.s_data = 8'hC1; step();
    bus4.s_data = 8'hC2; step();
    bus4.s_data = 8'hC3; step();
    bus4.s_valid = 1'b0;
    n_tests++;
    if (bus4.occupancy !== 3'd3) begin
      n_fail++;
      $display("FAIL mr_fill got o%0d exp o3", bus4.occupancy);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_tests++;
    if (bus4.m_valid !== 1'b0 || bus4.occupancy !== 3'd0 ||
        bus4.m_data !== RV4) begin
      n_fail++;
      $display("FAIL mr_state got v%b o%0d d%h exp v0 o0 d%h",
               bus4.m_valid, bus4.occupancy, bus4.m_data, RV4);
    end
    bus4.m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      n_tests++;
      if (bus4.m_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mr_ghost c%0d got v%b d%h exp v0",
                 c, bus4.m_valid, bus4.m_data);
      end
      step();
    end
  endtask

`ifdef EHL_DFF_PIPE_FLUSH_EN
  task automatic test_flush();
    bus4.m_ready = 1'b0;
    bus4.s_valid = 1'b1;
    bus4.s_data = 8'hD1; step();
    bus4.s_data = 8'hD2; step();
    bus4.s_data = 8'hD3;
    flush = 1'b1;
    #1;
    n_tests++;
    if (bus4.s_ready !== 1'b0 || bus4.occupancy !== 3'd2) begin
      n_fail++;
      $display("FAIL flush_in got r%b o%0d exp r0 o2",
               bus4.s_ready, bus4.occupancy);
    end
    step();
    flush = 1'b0;
    bus4.s_valid = 1'b0;
    n_tests++;
    if (bus4.occupancy !== 3'd0 || bus4.m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_out got o%0d v%b exp o0 v0",
               bus4.occupancy, bus4.m_valid);
    end
    bus4.m_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if (bus4.m_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_ghost c%0d got v%b exp v0",
                 c, bus4.m_valid);
      end
      step();
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic acc;
    int   cnt;
    bus4.s_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!(bus4.s_valid && !acc) || c == 0) begin
        bus4.s_valid = 1'($urandom_range(0, 1));
        bus4.s_data  = 8'($urandom);
      end
      bus4.m_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = bus4.s_valid & bus4.s_ready;
      step();
    end
    bus4.s_valid = 1'b0;
    bus4.m_ready = 1'b1;
    cnt = 0;
    while ((q4.size() != 0 || bus4.m_valid !== 1'b0) && cnt < 20) begin
      step();
      cnt++;
    end
    n_tests++;
    if (q4.size() != 0 || bus4.m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_timeout got q%0d v%b exp q0 v0",
               q4.size(), bus4.m_valid);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    mon_en = 1'b0;
    stall_prev = 1'b0;
    hold_prev = 8'h00;
    flush = 1'b0;
    test_reset();
    test_latency();
    test_backpressure();
    test_bubble();
    test_midreset();
`ifdef EHL_DFF_PIPE_FLUSH_EN
    test_flush();
`endif
    test_back_to_back();
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ehl_dff_pipe.md
# ehl_dff_pipe

Parametrised elastic register pipeline: a WIDTH-bit, DEPTH-stage chain of flip-flop stages with valid/ready handshaking on both sides. Bubbles collapse under stall. It generalises the single ehl_dff cell into a multi-bit, multi-stage retiming and buffering element. It is used for timing closure on long datapaths between blocks, and is technology-mappable through TECHNOLOGY like the other ehl_ primitives.

## Interface
- WIDTH, 8, data bits per stage (1..1024)
- DEPTH, 2, number of register stages (1..16)
- RESET_VALUE, 0, value loaded into every stage data register on reset
- TECHNOLOGY, 0, 0 = generic RTL flops; non-zero = mapped library cells (same encoding as ehl_dff)
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- s_valid  input  1  upstream data valid
- s_ready  output  1  pipeline accepts s_data this cycle
- s_data  input  WIDTH  upstream data
- m_valid  output  1  output stage holds valid data
- m_ready  input  1  downstream accepts m_data this cycle
- m_data  output  WIDTH  output stage data
- occupancy  output  $clog2(DEPTH+1)  number of valid stages
- flush  input  1  present only with EHL_DFF_PIPE_FLUSH_EN

## Operation
- State per stage i (0 = input side, DEPTH-1 = output): vld[i], dat[i].
- Ready chain is combinational: rdy[DEPTH-1] = !vld[DEPTH-1] | m_ready; rdy[i] = !vld[i] | rdy[i+1]. s_ready = rdy[0] & !reset.
- Stage i advances when rdy[i]: vld[i] <= upstream valid (s_valid for i=0, else vld[i-1]). dat[i] is loaded only if upstream valid is 1; otherwise dat[i] holds.
- When rdy[i] = 0, stage i holds both vld and dat.
- A bubble (vld=0) in any stage is filled while downstream is stalled.
- Handshake: a transfer occurs on s_valid & s_ready (input) and on m_valid & m_ready (output). Data order is strictly FIFO. No data is dropped or duplicated.
- m_valid = vld[DEPTH-1]; m_data = dat[DEPTH-1]. Both are registered outputs.
- occupancy is a registered counter:
  - +1 on input transfer only
  - -1 on output transfer only
  - unchanged when both or neither occur
  - It always equals the popcount of vld.
- Reset (synchronous, any cycle, including mid-transfer):
  - all vld <= 0; all dat <= RESET_VALUE; occupancy <= 0.
  - In-flight data is discarded. An input presented in the reset cycle is not accepted (s_ready = 0).
- Upstream must hold s_data stable while s_valid & !s_ready. The block guarantees the same on m_data while m_valid & !m_ready.

## Timing
- Empty pipeline, m_ready = 1: data accepted at edge N appears on m_data/m_valid after edge N+DEPTH-1, i.e. latency DEPTH cycles.
- Throughput: 1 word/cycle sustained while m_ready = 1.
- Full (occupancy = DEPTH) with m_ready = 0: s_ready = 0. Full with m_ready = 1: s_ready = 1 in the same cycle (pass-through ready, no lost cycle).
- m_ready -> s_ready is a combinational path through DEPTH stages. This is accepted; all other outputs are registered.
- Reset values: m_valid 0, m_data RESET_VALUE, occupancy 0, s_ready 0 while reset = 1 and 1 in the first cycle after.

## Configuration
- EHL_DFF_PIPE_FLUSH_EN defined: adds the flush input.
  - flush = 1 clears all vld and sets occupancy to 0 at the next edge. dat is untouched.
  - s_ready = 0 during flush.
  - flush and reset together behave as reset.
- Macro undefined: no flush port, no flush logic; behaviour is otherwise identical.

## Structure
- Shared package ehl_pkg holds:
  - EHL_DFF_PIPE_MAX_DEPTH = 16
  - a clog2 function for the occupancy width
  - the TECHNOLOGY encoding constants shared with ehl_dff
- Sub-module ehl_dff_pipe_stage: one vld bit plus a WIDTH-bit data register with load enable and synchronous reset, instantiated DEPTH times via generate. TECHNOLOGY is passed through to select generic or mapped flops.
- The top level contains the ready chain and the occupancy counter.

## Test plan
- Reset: hold reset 3 cycles with s_valid=1, s_data=8'hA5 -> m_valid=0, m_data=RESET_VALUE, occupancy=0, s_ready=0; after release s_ready=1.
- Latency: DEPTH=3, m_ready=1, single word 8'h3C at cycle 10 -> m_valid=1, m_data=8'h3C only at cycle 13; occupancy 1 for cycles 11..13.
- Back-pressure fill: DEPTH=4, m_ready=0, stream 1,2,3,4,5 -> words 1..4 accepted, s_ready=0 with word 5 held, occupancy=4. Then m_ready=1 -> outputs 1,2,3,4,5 in order, one per cycle.
- Bubble collapse: DEPTH=4, inputs at cycles 0 and 2 only, m_ready=0 from cycle 3 -> both words stored in stages 3 and 2, s_ready stays 1, occupancy=2.
- Mid-operation reset: occupancy=3, assert reset 1 cycle -> next cycle m_valid=0, occupancy=0, no old data emerges afterwards.
- Flush (EHL_DFF_PIPE_FLUSH_EN): occupancy=2, flush=1 with s_valid=1 -> input not accepted, occupancy=0, m_valid=0 next cycle. Compare RTL (TECHNOLOGY=0) against mapped (TECHNOLOGY=1) cycle-by-cycle with random stalls: zero mismatches.
